// File: rtl/risc_pkg.sv
// Shared definitions for the 5-stage RISC pipeline: opcode map, instruction
// field positions, immediate modifier codes and operand-usage helpers.
package risc_pkg;

  localparam int NREG = 16;
  localparam logic [3:0] RA_IDX = 4'd15;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_e;

  typedef enum logic [1:0] {
    MOD_SEXT  = 2'b00,
    MOD_ZEXT  = 2'b01,
    MOD_HIGH  = 2'b10,
    MOD_SEXT2 = 2'b11
  } imm_mod_e;

  // Instruction field bit positions.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int I_BIT  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 14;
  localparam int IMM_HI = 17;
  localparam int OFF_HI = 26;

  localparam logic [31:0] NOP_WORD = {OP_NOP, 27'd0};

  // Arithmetic/logic/shift group (add .. asr).
  function automatic logic is_alu(input logic [4:0] op);
    return op <= OP_ASR;
  endfunction

  // Instructions that read the rs1 field.
  function automatic logic uses_rs1(input logic [4:0] op);
    return (is_alu(op) && op != OP_NOT && op != OP_MOV) ||
           op == OP_LD || op == OP_ST;
  endfunction

  // Register-form ALU instructions read the rs2 field.
  function automatic logic uses_rs2(input logic [4:0] op, input logic ibit);
    return is_alu(op) && !ibit;
  endfunction

  // Expand the 18-bit immediate field according to its modifier bits.
  function automatic logic [31:0] make_imm(input logic [17:0] imm);
    logic [31:0] val;
    case (imm[17:16])
      MOD_ZEXT: val = {16'h0000, imm[15:0]};
      MOD_HIGH: val = {imm[15:0], 16'h0000};
      default:  val = {{16{imm[15]}}, imm[15:0]};
    endcase
    return val;
  endfunction

endpackage

// File: rtl/register_file.sv
// 16x32 architectural register file: three combinational read ports with
// write-through bypass, one synchronous write port, synchronous clear.
module register_file
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_idx_a,
  input  logic [3:0]  rd_idx_b,
  input  logic [3:0]  rd_idx_c,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic [31:0] rd_data_c
);

  logic [31:0] regs [NREG];

  // Register storage: cleared on reset, otherwise one write per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the architecture defines every register as zero after reset, so
      // this array is cleared explicitly; it is small enough to live in flops.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      regs[wr_idx] <= wr_data;
    end
  end

  // Read ports return the value being written this cycle when indices match.
  always_comb begin
    rd_data_a = (we && wr_idx == rd_idx_a) ? wr_data : regs[rd_idx_a];
    rd_data_b = (we && wr_idx == rd_idx_b) ? wr_data : regs[rd_idx_b];
    rd_data_c = (we && wr_idx == rd_idx_c) ? wr_data : regs[rd_idx_c];
  end

endmodule

// File: rtl/of_stage.sv
// Operand-fetch stage: decodes the IF instruction, reads operands, builds
// immediates and branch targets, detects load-use hazards and fills the
// OF/EX pipeline latch.
module of_stage
  import risc_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] If_pc,
  input  logic [31:0] If_instruction,
  input  logic        If_valid,
  input  logic        IsBranchTaken,
  input  logic        Rw_we,
  input  logic [3:0]  Rw_rd,
  input  logic [31:0] Rw_data,
  output logic        Stall,
  output logic        Of_valid,
  output logic [31:0] Of_pc,
  output logic [31:0] Of_instruction,
  output logic [4:0]  Of_opcode,
  output logic [3:0]  Of_rd,
  output logic [31:0] Of_op1,
  output logic [31:0] Of_op2,
  output logic [31:0] Of_store_val,
  output logic [31:0] Of_branch_target
);

  logic [4:0]  opcode;
  logic        ibit;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [17:0] imm;
  logic [26:0] offset;
  logic        is_ret;
  logic        legal;
  logic [3:0]  idx_a;
  logic [31:0] val_a;
  logic [31:0] val_b;
  logic [31:0] val_c;
  logic [31:0] op2_val;
  logic [31:0] target;
  logic        src_hit;
  logic        hazard;

  assign opcode = If_instruction[OPC_HI:OPC_LO];
  assign ibit   = If_instruction[I_BIT];
  assign rd     = If_instruction[RD_HI:RD_LO];
  assign rs1    = If_instruction[RS1_HI:RS1_LO];
  assign rs2    = If_instruction[RS2_HI:RS2_LO];
  assign imm    = If_instruction[IMM_HI:0];
  assign offset = If_instruction[OFF_HI:0];

  assign is_ret = (opcode == OP_RET);
  assign legal  = (opcode <= OP_RET);

  // ret reads the return-address register through the rs1 port.
  assign idx_a = is_ret ? RA_IDX : rs1;

  register_file u_register_file (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .we        (Rw_we),
    .wr_idx    (Rw_rd),
    .wr_data   (Rw_data),
    .rd_idx_a  (idx_a),
    .rd_idx_b  (rs2),
    .rd_idx_c  (rd),
    .rd_data_a (val_a),
    .rd_data_b (val_b),
    .rd_data_c (val_c)
  );

  assign op2_val = ibit ? make_imm(imm) : val_b;

  // Word offset, sign-extended; the add wraps modulo 2^32.
  assign target = If_pc + {{3{offset[26]}}, offset, 2'b00};

  // Load-use detection against the load currently held in the latch.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    src_hit = 1'b0;
    hazard  = 1'b0;
    if (uses_rs1(opcode) && rs1 == Of_rd)         src_hit = 1'b1;
    if (uses_rs2(opcode, ibit) && rs2 == Of_rd)   src_hit = 1'b1;
    if (opcode == OP_ST && rd == Of_rd)           src_hit = 1'b1;
    if (is_ret && RA_IDX == Of_rd)                src_hit = 1'b1;
    hazard = Of_valid && (Of_opcode == OP_LD) && If_valid && src_hit;
  end

  // A taken branch squashes the stage, so it never needs IF held.
  assign Stall = hazard && !IsBranchTaken;

  // OF/EX latch: reset, then flush, then bubble, then normal capture.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Of_valid         <= 1'b0;
      Of_pc            <= '0;
      Of_instruction   <= '0;
      Of_opcode        <= OP_NOP;
      Of_rd            <= '0;
      Of_op1           <= '0;
      Of_op2           <= '0;
      Of_store_val     <= '0;
      Of_branch_target <= '0;
    end else if (IsBranchTaken || hazard) begin
      Of_valid       <= 1'b0;
      Of_opcode      <= OP_NOP;
      Of_instruction <= NOP_WORD;
    end else begin
      Of_valid         <= If_valid && legal;
      Of_pc            <= If_pc;
      Of_instruction   <= If_instruction;
      Of_opcode        <= legal ? opcode : OP_NOP;
      Of_rd            <= rd;
      Of_op1           <= val_a;
      Of_op2           <= op2_val;
      Of_store_val     <= val_c;
      Of_branch_target <= target;
    end
  end

endmodule

// File: tb/tb_of_stage.sv
// Self-checking bench for of_stage: directed scenarios plus a randomized
// instruction stream compared against an architectural reference model.
module tb_of_stage;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] If_pc;
  logic [31:0] If_instruction;
  logic        If_valid;
  logic        IsBranchTaken;
  logic        Rw_we;
  logic [3:0]  Rw_rd;
  logic [31:0] Rw_data;
  logic        Stall;
  logic        Of_valid;
  logic [31:0] Of_pc;
  logic [31:0] Of_instruction;
  logic [4:0]  Of_opcode;
  logic [3:0]  Of_rd;
  logic [31:0] Of_op1;
  logic [31:0] Of_op2;
  logic [31:0] Of_store_val;
  logic [31:0] Of_branch_target;

  of_stage dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .If_pc            (If_pc),
    .If_instruction   (If_instruction),
    .If_valid         (If_valid),
    .IsBranchTaken    (IsBranchTaken),
    .Rw_we            (Rw_we),
    .Rw_rd            (Rw_rd),
    .Rw_data          (Rw_data),
    .Stall            (Stall),
    .Of_valid         (Of_valid),
    .Of_pc            (Of_pc),
    .Of_instruction   (Of_instruction),
    .Of_opcode        (Of_opcode),
    .Of_rd            (Of_rd),
    .Of_op1           (Of_op1),
    .Of_op2           (Of_op2),
    .Of_store_val     (Of_store_val),
    .Of_branch_target (Of_branch_target)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic [3:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sv;
    logic [31:0] tgt;
  } latch_t;

  latch_t      exp_l;
  bit          exp_known;
  bit          model_ready;
  bit          last_stall;
  logic [31:0] ref_regs [16];
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // Encoders for the instruction formats.
  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {5'(op), 1'b0, 4'(rd), 4'(rs1), 4'(rs2), 14'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs1, input int md, input logic [15:0] v);
    return {5'(op), 1'b1, 4'(rd), 4'(rs1), 2'(md), v};
  endfunction

  function automatic logic [31:0] enc_b(input int op, input logic [26:0] off);
    return {5'(op), off};
  endfunction

  // Does instruction w read architectural register r?
  function automatic bit src_reads(input logic [31:0] w, input logic [3:0] r);
    int op;
    bit alu;
    op  = int'(w[31:27]);
    alu = (op <= 12);
    if (op == 20) return r == 4'd15;
    if (op == 15 && w[25:22] == r) return 1'b1;
    if (((alu && op != 8 && op != 9) || op == 14 || op == 15) && w[21:18] == r) return 1'b1;
    if (alu && !w[26] && w[17:14] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    longint v;
    v = longint'(w[15:0]);
    case (w[17:16])
      2'b01:   return 32'(v);
      2'b10:   return 32'(v * 65536);
      default: return 32'((v >= 32768) ? v - 65536 : v);
    endcase
  endfunction

  function automatic logic [31:0] ref_tgt(input logic [31:0] pc, input logic [31:0] w);
    longint off;
    off = longint'(w[26:0]);
    if (off >= (64'sd1 <<< 26)) off = off - (64'sd1 <<< 27);
    return 32'(longint'(pc) + off * 4);
  endfunction

  function automatic logic [31:0] rd_val(input logic [3:0] idx);
    return (Rw_we && Rw_rd == idx) ? Rw_data : ref_regs[idx];
  endfunction

  // One clock: predict Stall and the next latch contents from current inputs.
  task automatic step(input string tag);
    bit     hz;
    bit     st;
    int     op;
    latch_t nx;
    #1;
    op = int'(If_instruction[31:27]);
    hz = exp_l.valid && exp_l.opcode == 5'd14 && If_valid && src_reads(If_instruction, exp_l.rd);
    st = hz && !IsBranchTaken;
    if (model_ready) check({tag, ".stall"}, 32'(Stall), 32'(st));
    nx = exp_l;
    if (!Rst_n) begin
      nx = '0;
      nx.opcode = 5'd13;
      exp_known = 1'b1;
      model_ready = 1'b1;
      for (int k = 0; k < 16; k++) ref_regs[k] = '0;
    end else begin
      if (IsBranchTaken || hz) begin
        nx.valid  = 1'b0;
        nx.opcode = 5'd13;
        exp_known = 1'b0;
      end else begin
        nx.pc    = If_pc;
        nx.instr = If_instruction;
        nx.rd    = If_instruction[25:22];
        nx.op1   = rd_val(op == 20 ? 4'd15 : If_instruction[21:18]);
        nx.op2   = If_instruction[26] ? ref_imm(If_instruction) : rd_val(If_instruction[17:14]);
        nx.sv    = rd_val(If_instruction[25:22]);
        nx.tgt   = ref_tgt(If_pc, If_instruction);
        if (op > 20) begin
          nx.valid  = 1'b0;
          nx.opcode = 5'd13;
          exp_known = 1'b0;
        end else begin
          nx.valid  = If_valid;
          nx.opcode = 5'(op);
          exp_known = 1'b1;
        end
      end
      if (Rw_we) ref_regs[Rw_rd] = Rw_data;
    end
    exp_l = nx;
    last_stall = st;
    @(posedge Clk);
    #1;
    check({tag, ".valid"}, 32'(Of_valid), 32'(exp_l.valid));
    check({tag, ".opcode"}, 32'(Of_opcode), 32'(exp_l.opcode));
    if (exp_known) begin
      check({tag, ".pc"}, Of_pc, exp_l.pc);
      check({tag, ".instr"}, Of_instruction, exp_l.instr);
      check({tag, ".rd"}, 32'(Of_rd), 32'(exp_l.rd));
      check({tag, ".op1"}, Of_op1, exp_l.op1);
      check({tag, ".op2"}, Of_op2, exp_l.op2);
      check({tag, ".store"}, Of_store_val, exp_l.sv);
      check({tag, ".target"}, Of_branch_target, exp_l.tgt);
    end
  endtask

  task automatic set_idle();
    If_valid       = 1'b0;
    If_pc          = '0;
    If_instruction = {5'd13, 27'd0};
    IsBranchTaken  = 1'b0;
    Rw_we          = 1'b0;
    Rw_rd          = '0;
    Rw_data        = '0;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] v);
    set_idle();
    Rw_we   = 1'b1;
    Rw_rd   = 4'(idx);
    Rw_data = v;
    step("wr");
    Rw_we = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] w);
    If_valid       = 1'b1;
    If_pc          = pc;
    If_instruction = w;
  endtask

  logic [31:0] imm_want [3];
  int          pick;
  logic [4:0]  r_op;

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_ready = 1'b0;
    exp_known   = 1'b0;
    last_stall  = 1'b0;
    exp_l       = '0;
    Rst_n       = 1'b0;
    set_idle();

    // Reset state.
    step("rst");
    step("rst2");
    check("rst.valid_lit", 32'(Of_valid), 32'd0);
    check("rst.opcode_lit", 32'(Of_opcode), 32'd13);
    check("rst.op1_lit", Of_op1, 32'd0);
    Rst_n = 1'b1;

    // Register-form add.
    write_reg(1, 32'd5);
    write_reg(2, 32'd7);
    present(32'h40, enc_r(0, 3, 1, 2));
    step("add");
    check("add.op1_lit", Of_op1, 32'd5);
    check("add.op2_lit", Of_op2, 32'd7);
    check("add.rd_lit", 32'(Of_rd), 32'd3);
    check("add.valid_lit", 32'(Of_valid), 32'd1);

    // Immediate modifiers.
    imm_want[0] = 32'hFFFF_FFFE;
    imm_want[1] = 32'h0000_FFFE;
    imm_want[2] = 32'hFFFE_0000;
    for (int m = 0; m < 3; m++) begin
      present(32'h44, enc_i(9, 1, 0, m, 16'hFFFE));
      step("imm");
      check("imm.op2_lit", Of_op2, imm_want[m]);
    end

    // Branch targets, including wrap-around.
    present(32'h100, enc_b(18, 27'h7FF_FFFF));
    step("br_neg");
    check("br_neg.target_lit", Of_branch_target, 32'h0000_00FC);
    present(32'hFFFF_FFFC, enc_b(18, 27'd1));
    step("br_wrap");
    check("br_wrap.target_lit", Of_branch_target, 32'h0000_0000);

    // Load-use: one stall, one bubble, then the consumer latches.
    present(32'h200, enc_i(14, 4, 1, 0, 16'd8));
    step("ld");
    present(32'h204, enc_r(0, 5, 4, 1));
    #1 check("lu.stall_lit", 32'(Stall), 32'd1);
    step("lu1");
    check("lu.bubble_lit", 32'(Of_valid), 32'd0);
    #1 check("lu.release_lit", 32'(Stall), 32'd0);
    step("lu2");
    check("lu.valid_lit", 32'(Of_valid), 32'd1);
    check("lu.rd_lit", 32'(Of_rd), 32'd5);

    // Load-use while a branch is taken: the flush wins.
    present(32'h300, enc_i(14, 4, 1, 0, 16'd8));
    step("ld2");
    present(32'h304, enc_r(0, 5, 4, 1));
    IsBranchTaken = 1'b1;
    #1 check("flush.stall_lit", 32'(Stall), 32'd0);
    step("flush");
    check("flush.valid_lit", 32'(Of_valid), 32'd0);
    IsBranchTaken = 1'b0;

    // Write-through bypass.
    present(32'h400, enc_r(0, 3, 2, 1));
    Rw_we   = 1'b1;
    Rw_rd   = 4'd2;
    Rw_data = 32'h0000_DEAD;
    step("byp");
    check("byp.op1_lit", Of_op1, 32'h0000_DEAD);
    Rw_we = 1'b0;

    // Reset clears every register.
    Rst_n = 1'b0;
    If_valid = 1'b0;
    step("rst3");
    Rst_n = 1'b1;
    check("rst3.valid_lit", 32'(Of_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      present(32'h500 + 32'(i * 4), enc_r(0, 0, i, i));
      step("clr");
      check("clr.op1_lit", Of_op1, 32'd0);
    end

    // Reset during a stall releases Stall the next cycle.
    present(32'h600, enc_i(14, 4, 1, 0, 16'd0));
    step("ld3");
    present(32'h604, enc_r(0, 5, 4, 1));
    Rst_n = 1'b0;
    step("rst_stall");
    Rst_n = 1'b1;
    #1 check("rst_stall.stall_lit", 32'(Stall), 32'd0);

    // Randomized stream; IF holds its word whenever a stall is predicted.
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        pick = int'($urandom_range(0, 99));
        r_op = (pick < 25) ? 5'd14 : 5'($urandom_range(0, 31));
        If_instruction = {r_op, 1'($urandom_range(0, 1)), rnd_reg(), rnd_reg(), rnd_reg(), 14'($urandom)};
        If_valid = ($urandom_range(0, 7) != 0);
        If_pc    = $urandom;
      end
      Rw_we         = 1'($urandom_range(0, 1));
      Rw_rd         = rnd_reg();
      Rw_data       = $urandom;
      IsBranchTaken = ($urandom_range(0, 9) == 0);
      Rst_n         = ($urandom_range(0, 99) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
